// File: rtl/postfix_evaluator.sv
// Postfix (RPN) expression evaluator: walks a token program from a ROM, delegates
// operand decode to a fetch unit and arithmetic to an external ALU, and keeps the operand stack internally.
module postfix_evaluator #(
    parameter int DATA_WIDTH      = 32,
    parameter int CODE_WIDTH      = 8,
    parameter int STACK_DEPTH     = 16,
    parameter int PROG_ADDR_WIDTH = 10
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [PROG_ADDR_WIDTH-1:0]         prog_base,
    output logic [PROG_ADDR_WIDTH-1:0]         prog_addr,
    input  logic [CODE_WIDTH-1:0]              prog_data,
    output logic                               fetch_start,
    output logic [CODE_WIDTH-1:0]              fetch_code,
    input  logic                               fetch_ready,
    input  logic [DATA_WIDTH-1:0]              fetch_value,
    output logic                               alu_start,
    output logic [2:0]                         alu_op,
    output logic [DATA_WIDTH-1:0]              operand_a,
    output logic [DATA_WIDTH-1:0]              operand_b,
    input  logic                               alu_ready,
    input  logic [DATA_WIDTH-1:0]              alu_result,
    output logic                               busy,
    output logic [DATA_WIDTH-1:0]              output_value,
    output logic                               output_ready,
    output logic                               error,
    output logic [1:0]                         error_code,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level
);

    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, READ, DECODE, WAIT_OPND, WAIT_ALU, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] stack [STACK_DEPTH];
    logic [IW-1:0]         top_idx;
    logic [IW-1:0]         below_idx;
    logic [IW-1:0]         push_idx;
    logic [1:0]            tok_class;
    logic [2:0]            tok_op;
    logic                  tok_end;

    assign top_idx   = IW'(stack_level - LW'(1));
    assign below_idx = IW'(stack_level - LW'(2));
    assign push_idx  = IW'(stack_level);
    assign tok_class = prog_data[CODE_WIDTH-1 -: 2];
    assign tok_op    = prog_data[2:0];
    assign tok_end   = &prog_data;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            prog_addr    <= '0;
            fetch_start  <= 1'b0;
            fetch_code   <= '0;
            alu_start    <= 1'b0;
            alu_op       <= '0;
            operand_a    <= '0;
            operand_b    <= '0;
            output_value <= '0;
            output_ready <= 1'b0;
            error        <= 1'b0;
            error_code   <= '0;
            stack_level  <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            fetch_start  <= 1'b0;
            alu_start    <= 1'b0;
            output_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        prog_addr   <= prog_base;
                        stack_level <= '0;
                        error       <= 1'b0;
                        error_code  <= '0;
                        state       <= READ;
                    end
                end
                READ: state <= DECODE;
                DECODE: begin
                    // END is checked before class decode: all-ones also carries class 11
                    if (tok_end) begin
                        if (stack_level == LW'(1)) begin
                            output_value <= stack[top_idx];
                            output_ready <= 1'b1;
                            state        <= DONE;
                        end else begin
                            error      <= 1'b1;
                            error_code <= 2'b01;
                            state      <= IDLE;
                        end
                    end else if (tok_class == 2'b10) begin
                        if (tok_op > 3'd4) begin
                            error      <= 1'b1;
                            error_code <= 2'b11;
                            state      <= IDLE;
                        end else if (stack_level < LW'(2)) begin
                            error      <= 1'b1;
                            error_code <= 2'b01;
                            state      <= IDLE;
                        end else begin
                            alu_op    <= tok_op;
                            operand_a <= stack[below_idx];
                            operand_b <= (tok_op == 3'b100)
                                       ? {~stack[top_idx][DATA_WIDTH-1], stack[top_idx][DATA_WIDTH-2:0]}
                                       : stack[top_idx];
                            alu_start <= 1'b1;
                            prog_addr <= prog_addr + PROG_ADDR_WIDTH'(1);
                            state     <= WAIT_ALU;
                        end
                    end else if (stack_level == LW'(STACK_DEPTH)) begin
                        error      <= 1'b1;
                        error_code <= 2'b10;
                        state      <= IDLE;
                    end else begin
                        fetch_code  <= prog_data;
                        fetch_start <= 1'b1;
                        prog_addr   <= prog_addr + PROG_ADDR_WIDTH'(1);
                        state       <= WAIT_OPND;
                    end
                end
                WAIT_OPND: begin
                    if (fetch_ready) begin
                        stack[push_idx] <= fetch_value;
                        stack_level     <= stack_level + LW'(1);
                        state           <= READ;
                    end
                end
                WAIT_ALU: begin
                    // result replaces the lower of the two consumed entries
                    if (alu_ready) begin
                        stack[below_idx] <= alu_result;
                        stack_level      <= stack_level - LW'(1);
                        state            <= READ;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_postfix_evaluator.sv
// Self-checking bench for postfix_evaluator: ROM, fetch and ALU responder models,
// with an output scoreboard queue and an ALU request queue.
module tb_postfix_evaluator;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int SD = 4;
    localparam int AW = 10;
    localparam int LW = $clog2(SD + 1);

    logic          clock;
    logic          reset;
    logic          start;
    logic [AW-1:0] prog_base;
    logic [AW-1:0] prog_addr;
    logic [CW-1:0] prog_data;
    logic          fetch_start;
    logic [CW-1:0] fetch_code;
    logic          fetch_ready;
    logic [DW-1:0] fetch_value;
    logic          alu_start;
    logic [2:0]    alu_op;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic          alu_ready;
    logic [DW-1:0] alu_result;
    logic          busy;
    logic [DW-1:0] output_value;
    logic          output_ready;
    logic          error;
    logic [1:0]    error_code;
    logic [LW-1:0] stack_level;

    postfix_evaluator #(
        .DATA_WIDTH(DW),
        .CODE_WIDTH(CW),
        .STACK_DEPTH(SD),
        .PROG_ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .prog_base(prog_base),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_start(fetch_start), .fetch_code(fetch_code),
        .fetch_ready(fetch_ready), .fetch_value(fetch_value),
        .alu_start(alu_start), .alu_op(alu_op),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_ready(alu_ready), .alu_result(alu_result),
        .busy(busy), .output_value(output_value), .output_ready(output_ready),
        .error(error), .error_code(error_code), .stack_level(stack_level)
    );

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] r;
    } alu_req_t;

    alu_req_t      alu_q[$];
    logic [DW-1:0] exp_q[$];
    logic [LW-1:0] lvl_q[$];
    logic [CW-1:0] rom [1 << AW];

    int n_checks = 0;
    int n_fail   = 0;
    int fetch_cnt = 0;
    int alu_cnt   = 0;
    int out_cnt   = 0;
    int busy_cycles = 0;
    int f_lat = 2;
    int a_lat = 3;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) prog_data <= rom[prog_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fval(input logic [CW-1:0] code);
        case (code)
            8'h01:   return 32'h40400000;
            8'h02:   return 32'h40000000;
            default: return {24'h0, code};
        endcase
    endfunction

    task automatic push_alu(input logic [2:0] op, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] r);
        alu_req_t e;
        e.op = op; e.a = a; e.b = b; e.r = r;
        alu_q.push_back(e);
    endtask

    task automatic kick(input logic [AW-1:0] base);
        prog_base = base;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_alu_start(input int budget);
        int n = 0;
        while (!alu_start && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!alu_start) check("alu_start_timeout", 32'(alu_start), 32'd1);
    endtask

    task automatic load_add_prog(input logic [CW-1:0] opcode);
        rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = opcode; rom[3] = 8'hFF;
    endtask

    // fetch unit model: answers each fetch_start after f_lat cycles
    initial begin
        logic [CW-1:0] c;
        fetch_ready = 1'b0;
        fetch_value = '0;
        forever begin
            @(negedge clock);
            if (fetch_start === 1'b1) begin
                c = fetch_code;
                fetch_cnt++;
                repeat (f_lat) @(negedge clock);
                if (busy) check("fetch_code_stable", 32'(fetch_code), 32'(c));
                fetch_value = fval(c);
                fetch_ready = 1'b1;
                @(negedge clock);
                fetch_ready = 1'b0;
                fetch_value = '0;
            end
        end
    end

    // ALU model: checks each request against the queue, answers after a_lat cycles
    initial begin
        alu_req_t r;
        alu_ready  = 1'b0;
        alu_result = '0;
        forever begin
            @(negedge clock);
            if (alu_start === 1'b1) begin
                alu_cnt++;
                if (alu_q.size() == 0) begin
                    check("alu_unexpected", 32'd1, 32'd0);
                end else begin
                    r = alu_q.pop_front();
                    check("alu_op", 32'(alu_op), 32'(r.op));
                    check("operand_a", operand_a, r.a);
                    check("operand_b", operand_b, r.b);
                    repeat (a_lat) @(negedge clock);
                    if (busy) check("operand_b_stable", operand_b, r.b);
                    alu_result = r.r;
                    alu_ready  = 1'b1;
                    @(negedge clock);
                    alu_ready  = 1'b0;
                    alu_result = '0;
                end
            end
        end
    end

    // output scoreboard and activity monitor
    initial begin
        logic          pending;
        logic [LW-1:0] last_lvl;
        pending  = 1'b0;
        last_lvl = '0;
        forever begin
            @(negedge clock);
            if (busy) busy_cycles++;
            if (stack_level !== last_lvl) begin
                lvl_q.push_back(stack_level);
                last_lvl = stack_level;
            end
            if (pending) begin
                check("busy_after_ready", 32'(busy), 32'd0);
                pending = 1'b0;
            end
            if (output_ready === 1'b1) begin
                out_cnt++;
                pending = 1'b1;
                check("busy_at_ready", 32'(busy), 32'd1);
                if (exp_q.size() == 0) check("output_unexpected", 32'd1, 32'd0);
                else check("output_value", output_value, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o, oa, f0;
        logic [AW-1:0] pa;
        reset = 1'b0; start = 1'b0; prog_base = '0;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'hFF;
        repeat (3) @(negedge clock);

        check("rst_prog_addr", 32'(prog_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stack_level", 32'(stack_level), 32'd0);
        check("rst_output_value", output_value, 32'd0);
        check("rst_output_ready", 32'(output_ready), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_error_code", 32'(error_code), 32'd0);
        check("rst_fetch_start", 32'(fetch_start), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 3.0 + 2.0
        load_add_prog(8'h83);
        push_alu(3'b011, 32'h40400000, 32'h40000000, 32'h40A00000);
        exp_q.push_back(32'h40A00000);
        lvl_q.delete();
        busy_cycles = 0;
        o = out_cnt;
        kick(10'h000);
        wait_idle(200);
        check("add_busy_cycles", 32'(busy_cycles), 32'd19);
        check("add_out_pulses", 32'(out_cnt - o), 32'd1);
        check("add_error", 32'(error), 32'd0);
        check("add_result_held", output_value, 32'h40A00000);
        check("add_level_trace_len", 32'(lvl_q.size()), 32'd3);
        if (lvl_q.size() == 3) begin
            check("add_level_0", 32'(lvl_q[0]), 32'd1);
            check("add_level_1", 32'(lvl_q[1]), 32'd2);
            check("add_level_2", 32'(lvl_q[2]), 32'd1);
        end

        // 3.0 - 2.0, with a start pulse while busy
        load_add_prog(8'h84);
        push_alu(3'b100, 32'h40400000, 32'hC0000000, 32'h3F800000);
        exp_q.push_back(32'h3F800000);
        a_lat = 6;
        kick(10'h000);
        wait_alu_start(100);
        pa = prog_addr;
        prog_base = 10'h155;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_start_ignored", 32'(prog_addr), 32'(pa));
        check("busy_during_start", 32'(busy), 32'd1);
        wait_idle(200);
        a_lat = 3;
        check("sub_result", output_value, 32'h3F800000);
        check("sub_error", 32'(error), 32'd0);

        // underflow on operator
        rom[0] = 8'h01; rom[1] = 8'h83; rom[2] = 8'hFF;
        oa = alu_cnt; o = out_cnt;
        kick(10'h000);
        wait_idle(200);
        check("uf_error", 32'(error), 32'd1);
        check("uf_error_code", 32'(error_code), 32'd1);
        check("uf_no_alu", 32'(alu_cnt - oa), 32'd0);
        check("uf_no_output", 32'(out_cnt - o), 32'd0);
        check("uf_output_kept", output_value, 32'h3F800000);

        // overflow on fifth operand with a 4-deep stack
        for (int i = 0; i < 5; i++) rom[i] = 8'h01;
        rom[5] = 8'hFF;
        f0 = fetch_cnt; o = out_cnt;
        kick(10'h000);
        wait_idle(300);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_error_code", 32'(error_code), 32'd2);
        check("ovf_stack_level", 32'(stack_level), 32'd4);
        check("ovf_fetches", 32'(fetch_cnt - f0), 32'd4);
        check("ovf_prog_addr", 32'(prog_addr), 32'd4);
        check("ovf_no_output", 32'(out_cnt - o), 32'd0);

        // illegal opcode, then recovery
        rom[0] = 8'h87;
        kick(10'h000);
        wait_idle(50);
        check("ill_error", 32'(error), 32'd1);
        check("ill_error_code", 32'(error_code), 32'd3);
        check("ill_prog_addr", 32'(prog_addr), 32'd0);
        load_add_prog(8'h83);
        push_alu(3'b011, 32'h40400000, 32'h40000000, 32'h40A00000);
        exp_q.push_back(32'h40A00000);
        kick(10'h000);
        check("error_cleared", 32'(error), 32'd0);
        check("error_code_cleared", 32'(error_code), 32'd0);
        wait_idle(200);
        check("recover_result", output_value, 32'h40A00000);
        check("recover_error", 32'(error), 32'd0);

        // address wrap
        rom[10'h3FF] = 8'h01; rom[0] = 8'hFF;
        exp_q.push_back(32'h40400000);
        kick(10'h3FF);
        wait_idle(100);
        check("wrap_prog_addr", 32'(prog_addr), 32'd0);
        check("wrap_result", output_value, 32'h40400000);
        check("wrap_error", 32'(error), 32'd0);

        // reset while waiting on the ALU; the late alu_ready must be ignored
        load_add_prog(8'h83);
        push_alu(3'b011, 32'h40400000, 32'h40000000, 32'h40A00000);
        a_lat = 6;
        o = out_cnt;
        kick(10'h000);
        wait_alu_start(100);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_level", 32'(stack_level), 32'd0);
        check("mid_rst_prog_addr", 32'(prog_addr), 32'd0);
        check("mid_rst_output_value", output_value, 32'd0);
        check("mid_rst_operand_b", operand_b, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (8) @(negedge clock);
        a_lat = 3;
        check("late_ready_busy", 32'(busy), 32'd0);
        check("late_ready_level", 32'(stack_level), 32'd0);
        check("late_ready_no_output", 32'(out_cnt - o), 32'd0);
        check("late_ready_error", 32'(error), 32'd0);

        // first run after reset behaves as from power-up
        push_alu(3'b011, 32'h40400000, 32'h40000000, 32'h40A00000);
        exp_q.push_back(32'h40A00000);
        kick(10'h000);
        wait_idle(200);
        check("post_rst_result", output_value, 32'h40A00000);
        check("post_rst_error", 32'(error), 32'd0);

        repeat (2) @(negedge clock);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("alu_q_drained", 32'(alu_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
